// File: rtl/fp16_wb_packer_if.sv
// Writeback stream bundle: MAC result beats in, packed/forwarded words out.
// master drives the input beats and consumes words; slave is the packer.
interface fp16_wb_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic [4:0]  in_flags;
    logic        in_last;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [4:0]  out_flags;
    logic        out_last;

    modport master (
        output in_valid, in_data, in_flags, in_last, out_ready,
        input  in_ready, out_valid, out_data, out_flags, out_last
    );

    modport slave (
        input  in_valid, in_data, in_flags, in_last, out_ready,
        output in_ready, out_valid, out_data, out_flags, out_last
    );
endinterface

// File: rtl/fp16_wb_packer.sv
// FP32 result writeback: passthrough, or FP32->FP16 (RNE) conversion packing two halves per word.
// Define WB_FP16_SUBNORM_EN to produce FP16 subnormals instead of flushing them to signed zero.
module fp16_wb_packer #(
    parameter bit LO_FIRST = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    fp16_wb_if.slave   bus,
    input  logic       mode,
    input  logic       flags_clr,
    output logic [4:0] flags_sticky,
    output logic       busy
);

    // Flag bit positions inside {NV,DZ,OF,UF,NX}
    localparam logic [4:0] FL_NV = 5'b10000;
    localparam logic [4:0] FL_OF = 5'b00100;
    localparam logic [4:0] FL_UF = 5'b00010;
    localparam logic [4:0] FL_NX = 5'b00001;

    typedef enum logic [1:0] {
        IDLE,
        RUN32,
        RUN16_LO,
        RUN16_HI
    } state_t;

    function automatic logic rne_inc(input logic lsb, input logic guard, input logic sticky);
        return guard & (sticky | lsb);
    endfunction

    function automatic logic [15:0] sat_inf16(input logic sign);
        return {sign, 5'h1F, 10'h000};
    endfunction

    // Returns {flags[4:0], half[15:0]}
    function automatic logic [20:0] conv_fp16(input logic [31:0] f);
        logic               s;
        logic [7:0]         e;
        logic [22:0]        m;
        logic signed [9:0]  hexp;
        logic [14:0]        mag;
        logic               g;
        logic               st;
        logic [15:0]        h;
        logic [4:0]         fl;
`ifdef WB_FP16_SUBNORM_EN
        logic [5:0]         sh;
        logic [63:0]        ext;
`endif
        s    = f[31];
        e    = f[30:23];
        m    = f[22:0];
        hexp = $signed({2'b00, e}) - 10'sd112;
        h    = {s, 15'h0000};
        fl   = 5'b00000;
        mag  = 15'h0000;
        g    = 1'b0;
        st   = 1'b0;
        if (e == 8'hFF) begin
            if (m != 23'd0) begin
                h  = {s, 5'h1F, (m[22:13] != 10'd0) ? m[22:13] : 10'h200};
                fl = FL_NV;
            end else begin
                h = sat_inf16(s);
            end
        end else if (e == 8'h00 && m == 23'd0) begin
            h = {s, 15'h0000};
        end else if (hexp >= 10'sd31) begin
            h  = sat_inf16(s);
            fl = FL_OF | FL_NX;
        end else if (hexp >= 10'sd1) begin
            g   = m[12];
            st  = |m[11:0];
            mag = {hexp[4:0], m[22:13]} + {14'd0, rne_inc(m[13], g, st)};
            // Rounding carry may push the exponent field to all-ones
            if (mag[14:10] == 5'h1F) begin
                h  = sat_inf16(s);
                fl = FL_OF | FL_NX;
            end else begin
                h  = {s, mag};
                fl = (g | st) ? FL_NX : 5'b00000;
            end
        end else begin
`ifdef WB_FP16_SUBNORM_EN
            if (hexp < -10'sd24) begin
                h  = {s, 15'h0000};
                fl = FL_UF | FL_NX;
            end else begin
                // Significand in units of 2^-24 is {1,m} >> (14 - hexp)
                sh  = 6'(10'sd14 - hexp);
                ext = {1'b1, m, 40'd0} >> sh;
                g   = ext[39];
                st  = |ext[38:0];
                mag = {4'd0, ext[50:40]} + {14'd0, rne_inc(ext[40], g, st)};
                h   = {s, mag};
                if (mag == 15'd0) begin
                    fl = FL_UF | FL_NX;
                end else begin
                    fl = (g | st) ? FL_NX : 5'b00000;
                end
            end
`else
            h  = {s, 15'h0000};
            fl = FL_UF | FL_NX;
`endif
        end
        return {fl, h};
    endfunction

    state_t      state_q, state_d;
    logic [15:0] hold_q, hold_d;
    logic [4:0]  hold_f_q, hold_f_d;
    logic        out_valid_q, out_valid_d;
    logic [31:0] out_data_q, out_data_d;
    logic [4:0]  out_flags_q, out_flags_d;
    logic        out_last_q, out_last_d;
    logic [4:0]  sticky_q, sticky_d;

    logic        in_ready;
    logic        in_acc;
    logic        out_hs;
    logic        beat32;
    logic [20:0] conv_res;
    logic [15:0] cv_h;
    logic [4:0]  cv_f;
    logic        emit;
    logic [31:0] word;
    logic [4:0]  word_f;
    logic        word_l;

    assign in_ready = !out_valid_q | bus.out_ready;
    assign in_acc   = bus.in_valid & in_ready;
    assign out_hs   = out_valid_q & bus.out_ready;
    assign conv_res = conv_fp16(bus.in_data);
    assign cv_h     = conv_res[15:0];
    assign cv_f     = conv_res[20:16];
    // mode only matters on the opening beat; afterwards the state remembers it
    assign beat32   = (state_q == IDLE) ? mode : (state_q == RUN32);

    always_comb begin
        state_d  = state_q;
        hold_d   = hold_q;
        hold_f_d = hold_f_q;
        emit     = 1'b0;
        word     = 32'd0;
        word_f   = 5'd0;
        word_l   = 1'b0;
        if (in_acc) begin
            if (beat32) begin
                emit    = 1'b1;
                word    = bus.in_data;
                word_f  = bus.in_flags;
                word_l  = bus.in_last;
                state_d = bus.in_last ? IDLE : RUN32;
            end else if (state_q == RUN16_HI) begin
                emit     = 1'b1;
                word     = LO_FIRST ? {cv_h, hold_q} : {hold_q, cv_h};
                word_f   = hold_f_q | bus.in_flags | cv_f;
                word_l   = bus.in_last;
                hold_d   = 16'd0;
                hold_f_d = 5'd0;
                state_d  = bus.in_last ? IDLE : RUN16_LO;
            end else if (bus.in_last) begin
                emit    = 1'b1;
                word    = LO_FIRST ? {16'h0000, cv_h} : {cv_h, 16'h0000};
                word_f  = bus.in_flags | cv_f;
                word_l  = 1'b1;
                state_d = IDLE;
            end else begin
                hold_d   = cv_h;
                hold_f_d = bus.in_flags | cv_f;
                state_d  = RUN16_HI;
            end
        end
    end

    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_flags_d = out_flags_q;
        out_last_d  = out_last_q;
        if (emit) begin
            out_valid_d = 1'b1;
            out_data_d  = word;
            out_flags_d = word_f;
            out_last_d  = word_l;
        end else if (out_hs) begin
            out_valid_d = 1'b0;
            out_data_d  = 32'd0;
            out_flags_d = 5'd0;
            out_last_d  = 1'b0;
        end
    end

    // A clear coinciding with a handshake keeps only that word's flags
    always_comb begin
        sticky_d = sticky_q;
        if (flags_clr) begin
            sticky_d = out_hs ? out_flags_q : 5'd0;
        end else if (out_hs) begin
            sticky_d = sticky_q | out_flags_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            hold_q      <= 16'd0;
            hold_f_q    <= 5'd0;
            out_valid_q <= 1'b0;
            out_data_q  <= 32'd0;
            out_flags_q <= 5'd0;
            out_last_q  <= 1'b0;
            sticky_q    <= 5'd0;
        end else begin
            state_q     <= state_d;
            hold_q      <= hold_d;
            hold_f_q    <= hold_f_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_flags_q <= out_flags_d;
            out_last_q  <= out_last_d;
            sticky_q    <= sticky_d;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_flags = out_flags_q;
    assign bus.out_last  = out_last_q;
    assign flags_sticky  = sticky_q;
    assign busy          = (state_q != IDLE) | out_valid_q;

endmodule

// File: tb/tb_fp16_wb_packer.sv
// Bench for fp16_wb_packer: directed vector table, hand-written corner sequences,
// and a randomized run scored against an arithmetic FP32->FP16 reference model.
module tb_fp16_wb_packer;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       mode = 1'b0;
    logic       flags_clr = 1'b0;
    logic [4:0] flags_sticky;
    logic       busy;

    fp16_wb_if bus();

    fp16_wb_packer #(.LO_FIRST(1'b1)) dut (
        .clk          (clk),
        .rst          (rst),
        .bus          (bus),
        .mode         (mode),
        .flags_clr    (flags_clr),
        .flags_sticky (flags_sticky),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] data;
        logic [4:0]  flags;
        logic        last;
    } word_t;

    typedef struct {
        logic        md;
        int          n;
        logic [31:0] a;
        logic [4:0]  fa;
        logic [31:0] b;
        logic [4:0]  fb;
        logic [31:0] ed;
        logic [4:0]  ef;
    } vec_t;

    int checks = 0;
    int errors = 0;

    // Reference model state: packet open, its mode, a held half
    bit          m_open;
    bit          m_mode32;
    bit          m_held;
    logic [15:0] m_hold;
    logic [4:0]  m_holdf;
    word_t       m_q[$];
    logic [4:0]  m_sticky;
    word_t       got_hist[$];
    bit          last_acc;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Value-based conversion: scale the significand to the target ulp and round half-even.
    function automatic logic [20:0] ref_conv(input logic [31:0] f);
        logic        s;
        int          e, ee, p, ue, k, bexp;
        longint      sig, q, r, hf;
        bit          inexact;
        logic [15:0] h;
        logic [4:0]  fl;
        s  = f[31];
        e  = int'(f[30:23]);
        fl = 5'b00000;
        if (e == 255) begin
            if (f[22:0] != 23'd0) begin
                h = {s, 5'h1F, (f[22:13] != 10'd0) ? f[22:13] : 10'h200};
                return {5'b10000, h};
            end
            return {5'b00000, s, 15'h7C00};
        end
        if (f[30:0] == 31'd0) return {5'b00000, s, 15'h0000};
        sig = (e == 0) ? longint'(f[22:0]) : longint'({1'b1, f[22:0]});
        ee  = (e == 0) ? -149 : e - 150;
        p   = (e == 0) ? -127 : e - 127;
`ifndef WB_FP16_SUBNORM_EN
        if (p < -14) return {5'b00011, s, 15'h0000};
`endif
        ue = (p >= -14) ? p - 10 : -24;
        k  = ue - ee;
        if (k > 40) begin
            q = 0;
            inexact = 1'b1;
        end else begin
            q  = sig >>> k;
            r  = sig - (q <<< k);
            hf = longint'(1) <<< (k - 1);
            if (r > hf || (r == hf && q[0])) q = q + 1;
            inexact = (r != 0);
        end
        if (q == 0) return {5'b00011, s, 15'h0000};
        if (q == 2048) begin
            q  = 1024;
            ue = ue + 1;
        end
        fl[0] = inexact;
        if (q >= 1024) begin
            bexp = ue + 25;
            if (bexp >= 31) return {5'b00101, s, 15'h7C00};
            h = {s, bexp[4:0], q[9:0]};
        end else begin
            h = {s, 5'd0, q[9:0]};
        end
        return {fl, h};
    endfunction

    task automatic model_reset();
        m_open = 0; m_mode32 = 0; m_held = 0;
        m_hold = '0; m_holdf = '0; m_sticky = '0;
        m_q.delete();
    endtask

    task automatic model_beat(input logic [31:0] d, input logic [4:0] fl, input logic last, input logic md);
        logic [20:0] rc;
        word_t       w;
        if (!m_open) begin
            m_open = 1; m_mode32 = md; m_held = 0;
        end
        rc = ref_conv(d);
        if (m_mode32) begin
            w.data = d; w.flags = fl; w.last = last;
            m_q.push_back(w);
        end else if (m_held) begin
            w.data = {rc[15:0], m_hold}; w.flags = m_holdf | fl | rc[20:16]; w.last = last;
            m_q.push_back(w);
            m_held = 0;
        end else if (last) begin
            w.data = {16'h0000, rc[15:0]}; w.flags = fl | rc[20:16]; w.last = 1'b1;
            m_q.push_back(w);
        end else begin
            m_held = 1; m_hold = rc[15:0]; m_holdf = fl | rc[20:16];
        end
        if (last) begin
            m_open = 0; m_held = 0;
        end
    endtask

    // One clock: check outputs mid-cycle, score handshakes, advance past the edge.
    task automatic step();
        bit    hs, acc, exp_v;
        word_t w;
        #3;
        exp_v = (m_q.size() != 0);
        chk("out_valid", 64'(bus.out_valid), 64'(exp_v));
        if (exp_v) chk("out_word", 64'({bus.out_data, bus.out_flags, bus.out_last}),
                       64'({m_q[0].data, m_q[0].flags, m_q[0].last}));
        chk("in_ready", 64'(bus.in_ready), 64'(!exp_v || bus.out_ready));
        chk("busy", 64'(busy), 64'(m_open || exp_v));
        chk("sticky", 64'(flags_sticky), 64'(m_sticky));
        hs  = exp_v && bus.out_ready;
        acc = bus.in_valid && (!exp_v || bus.out_ready);
        last_acc = acc;
        if (hs) begin
            w = m_q.pop_front();
            got_hist.push_back('{bus.out_data, bus.out_flags, bus.out_last});
            if (flags_clr) m_sticky = w.flags;
            else           m_sticky = m_sticky | w.flags;
        end else if (flags_clr) begin
            m_sticky = 5'd0;
        end
        if (acc) model_beat(bus.in_data, bus.in_flags, bus.in_last, mode);
        @(posedge clk);
        #1;
    endtask

    task automatic send_beat(input logic [31:0] d, input logic [4:0] fl, input logic last, input logic md);
        int n;
        bus.in_valid = 1'b1; bus.in_data = d; bus.in_flags = fl; bus.in_last = last; mode = md;
        n = 0;
        do begin
            step();
            n++;
        end while (!last_acc && n < 50);
        if (!last_acc) chk("beat_timeout", 64'(0), 64'(1));
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_words(input int target);
        int n;
        n = 0;
        while (got_hist.size() < target && n < 20) begin
            step();
            n++;
        end
        if (got_hist.size() < target) chk("word_timeout", 64'(got_hist.size()), 64'(target));
    endtask

    task automatic send_pkt(input vec_t v, input string name);
        int base;
        base = got_hist.size();
        bus.out_ready = 1'b1;
        send_beat(v.a, v.fa, v.n == 1, v.md);
        if (v.n == 2) send_beat(v.b, v.fb, 1'b1, v.md);
        wait_words(base + 1);
        if (got_hist.size() > base) begin
            chk({name, "_data"}, 64'(got_hist[base].data), 64'(v.ed));
            chk({name, "_flags"}, 64'(got_hist[base].flags), 64'(v.ef));
            chk({name, "_last"}, 64'(got_hist[base].last), 64'(1));
        end
    endtask

    function automatic logic [31:0] rnd_fp32();
        logic [31:0] v;
        logic [7:0]  ex;
        v = $urandom;
        case ($urandom_range(0, 9))
            0: v = $urandom;
            1: begin
                case ($urandom_range(0, 3))
                    0: v = {v[31], 8'hFF, 23'd0};
                    1: v = {v[31], 8'hFF, v[22:0] | 23'd1};
                    2: v = {v[31], 31'd0};
                    default: v = {v[31], 8'h00, v[22:0]};
                endcase
            end
            2: begin
                ex = 8'($urandom_range(100, 142));
                v  = {v[31], ex, v[22:13], 13'h1000};
            end
            default: begin
                ex = 8'($urandom_range(95, 146));
                v  = {v[31], ex, v[22:0]};
            end
        endcase
        return v;
    endfunction

    vec_t vecs[9];

    initial begin
        int base;
        vecs[0] = '{1'b0, 2, 32'h3F800000, 5'h00, 32'h40000000, 5'h00, 32'h40003C00, 5'b00000};
        vecs[1] = '{1'b0, 1, 32'hC0490FDB, 5'h00, 32'h00000000, 5'h00, 32'h0000C248, 5'b00001};
        vecs[2] = '{1'b0, 2, 32'h47800000, 5'h00, 32'h7FC00000, 5'h00, 32'h7E007C00, 5'b10101};
`ifdef WB_FP16_SUBNORM_EN
        vecs[3] = '{1'b0, 2, 32'h33800000, 5'h00, 32'h00000000, 5'h00, 32'h00000001, 5'b00000};
`else
        vecs[3] = '{1'b0, 2, 32'h33800000, 5'h00, 32'h00000000, 5'h00, 32'h00000000, 5'b00011};
`endif
        vecs[4] = '{1'b1, 1, 32'h12345678, 5'b01010, 32'h0, 5'h00, 32'h12345678, 5'b01010};
        vecs[5] = '{1'b0, 2, 32'h3F800001, 5'b01000, 32'hBF800000, 5'h00, 32'hBC003C00, 5'b01001};
        vecs[6] = '{1'b0, 2, 32'h477FE000, 5'h00, 32'h477FF000, 5'h00, 32'h7C007BFF, 5'b00101};
        vecs[7] = '{1'b0, 2, 32'h3F801000, 5'h00, 32'h3F803000, 5'h00, 32'h3C023C00, 5'b00001};
        vecs[8] = '{1'b0, 2, 32'hFF800000, 5'h00, 32'h7F800001, 5'h00, 32'h7E00FC00, 5'b10000};

        bus.in_valid = 1'b0; bus.in_data = '0; bus.in_flags = '0; bus.in_last = 1'b0;
        bus.out_ready = 1'b0;
        model_reset();
        #1 rst = 1'b1;
        @(posedge clk); @(posedge clk); #1;
        chk("rst_out_valid", 64'(bus.out_valid), 64'(0));
        chk("rst_out_data", 64'(bus.out_data), 64'(0));
        chk("rst_out_flags", 64'(bus.out_flags), 64'(0));
        chk("rst_out_last", 64'(bus.out_last), 64'(0));
        chk("rst_sticky", 64'(flags_sticky), 64'(0));
        chk("rst_busy", 64'(busy), 64'(0));
        rst = 1'b0;
        step();

        for (int i = 0; i < 9; i++) begin
            send_pkt(vecs[i], $sformatf("vec%0d", i));
            step();
        end

        // Specials word lands in the sticky register, then a lone clear empties it
        flags_clr = 1'b1; step(); flags_clr = 1'b0;
        send_pkt(vecs[2], "sticky_pkt");
        step();
        chk("sticky_specials", 64'(flags_sticky), 64'(5'b10101));
        flags_clr = 1'b1; step(); flags_clr = 1'b0;
        chk("sticky_cleared", 64'(flags_sticky), 64'(0));

        // FP32 stream with three stalled cycles after the first word
        base = got_hist.size();
        bus.out_ready = 1'b0;
        send_beat(32'hAAAA0001, 5'b00001, 1'b0, 1'b1);
        bus.in_valid = 1'b1; bus.in_data = 32'hBBBB0002; bus.in_flags = 5'b00110; bus.in_last = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("bp_in_ready", 64'(bus.in_ready), 64'(0));
            chk("bp_hold_data", 64'(bus.out_data), 64'(32'hAAAA0001));
            chk("bp_hold_flags", 64'(bus.out_flags), 64'(5'b00001));
        end
        bus.out_ready = 1'b1;
        send_beat(32'hBBBB0002, 5'b00110, 1'b0, 1'b0);
        send_beat(32'hCCCC0003, 5'b11000, 1'b1, 1'b0);
        wait_words(base + 3);
        if (got_hist.size() >= base + 3) begin
            chk("bp_w0", 64'({got_hist[base].data, got_hist[base].flags}), 64'({32'hAAAA0001, 5'b00001}));
            chk("bp_w1", 64'({got_hist[base+1].data, got_hist[base+1].flags}), 64'({32'hBBBB0002, 5'b00110}));
            chk("bp_w2", 64'({got_hist[base+2].data, got_hist[base+2].flags, got_hist[base+2].last}),
                64'({32'hCCCC0003, 5'b11000, 1'b1}));
        end
        step();

        // Reset while one half is held must leave nothing behind
        send_beat(32'h3F800000, 5'b00100, 1'b0, 1'b0);
        #2 rst = 1'b1;
        #1;
        model_reset();
        chk("mid_rst_valid", 64'(bus.out_valid), 64'(0));
        chk("mid_rst_data", 64'(bus.out_data), 64'(0));
        chk("mid_rst_flags", 64'(bus.out_flags), 64'(0));
        chk("mid_rst_busy", 64'(busy), 64'(0));
        @(posedge clk); #1;
        rst = 1'b0;
        step();
        send_pkt(vecs[0], "post_rst");
        step();

        // Randomized traffic: random valid/ready/clear, mode toggling mid-packet
        bus.in_data = rnd_fp32(); bus.in_flags = 5'($urandom); bus.in_last = ($urandom_range(0, 3) == 0);
        mode = 1'($urandom);
        for (int c = 0; c < 3000; c++) begin
            bus.in_valid  = ($urandom_range(0, 9) < 7);
            bus.out_ready = ($urandom_range(0, 9) < 7);
            flags_clr     = ($urandom_range(0, 19) == 0);
            step();
            if (last_acc) begin
                bus.in_data  = rnd_fp32();
                bus.in_flags = 5'($urandom);
                bus.in_last  = ($urandom_range(0, 3) == 0);
                mode         = 1'($urandom);
            end
        end
        bus.in_valid = 1'b0; bus.out_ready = 1'b1; flags_clr = 1'b0;
        for (int i = 0; i < 5; i++) step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fp16_wb_packer.md
# fp16_wb_packer

Writeback sequencer between the MAC result stream and the register/buffer write port. In FP32 mode it forwards results unchanged. In FP16 mode it converts each FP32 result to IEEE half precision with round-to-nearest-even, packs two consecutive halves into one 32-bit word and merges exception flags. It also keeps a sticky flag register for the CSR path.

## Interface
- LO_FIRST, 1: 1 = first beat of a pair goes to out_data[15:0]; 0 = first beat goes to [31:16].
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  input beat valid.
- in_ready  out  1  input beat accepted when in_valid & in_ready.
- in_data  in  32  FP32 result.
- in_flags  in  5  upstream flags {NV,DZ,OF,UF,NX}.
- in_last  in  1  last beat of packet.
- mode  in  1  1 = FP32 passthrough, 0 = FP16 pack; sampled on first beat of a packet.
- out_valid  out  1  output word valid.
- out_ready  in  1  downstream accept.
- out_data  out  32  output word.
- out_flags  out  5  merged flags of the word.
- out_last  out  1  last word of packet.
- flags_sticky  out  5  OR of out_flags over all accepted words.
- flags_clr  in  1  clear flags_sticky.
- busy  out  1  packet in progress or output pending.

## Operation
- States:
  - IDLE: no packet open.
  - RUN32: FP32 packet open.
  - RUN16_LO: FP16 packet open, no half held.
  - RUN16_HI: FP16 packet open, one half held.
- Accepted beat in IDLE: latch mode into pkt_mode, then process the beat per pkt_mode. mode is ignored in every other state.
- RUN32 / FP32 beat: write output register with {in_data, in_flags, in_last}.
- FP16 beat in RUN16_LO, not last:
  - store conv(in_data) in hold_q.
  - store in_flags | conv_flags in hold_f.
  - go to RUN16_HI; no output written.
- FP16 beat in RUN16_LO with in_last (odd tail): emit word = held-position half, other half 16'h0000; out_last=1.
- FP16 beat in RUN16_HI: emit word = {conv(second), hold_q} when LO_FIRST=1, else the swapped order.
  - out_flags = hold_f | in_flags | conv_flags.
  - out_last = in_last.
  - next state is RUN16_LO, or IDLE if in_last.
- Any beat with in_last returns the block to IDLE.
- Conversion is FP32→FP16 with RNE:
  - NaN → sign, 5'h1F, mant[22:13]; if that field is 0, use 10'h200. NV=1.
  - ±Inf → 0x7C00 / 0xFC00, no flags.
  - Finite result rounding to beyond max → ±Inf, OF=1, NX=1.
  - Half-exponent ≤ 0 → subnormal per Configuration. A result of ±0 from a nonzero input sets UF=1 and NX=1.
  - NX=1 whenever discarded bits are nonzero.
  - Mantissa carry increments the exponent; recheck overflow after the carry.
- flags_sticky: on each out handshake, OR in out_flags.
  - flags_clr alone → 0.
  - flags_clr together with a handshake → out_flags of that word only.
- busy = (state != IDLE) | out_valid.

## Timing
- Reset values: out_valid=0, out_data=0, out_flags=0, out_last=0, flags_sticky=0, busy=0, state=IDLE, hold_q=0, hold_f=0.
- in_ready = !out_valid | out_ready. This is combinational and identical in every state.
- Output register: set on a beat that emits a word, cleared on out handshake with no new word, overwritten on simultaneous handshake plus new word.
- Latency: an emitting beat accepted in cycle N gives out_valid in cycle N+1. Sustained throughput is 1 beat/cycle in, 1 word/cycle (FP32) or 1 word per 2 cycles (FP16) out.
- out_* hold stable while out_valid & !out_ready.
- Reset asserted mid-packet drops hold_q and the pending word; no partial word is emitted after release.

## Configuration
- WB_FP16_SUBNORM_EN defined:
  - Half-exponent in [-24..0] produces an RNE subnormal.
  - Below -24, the result is ±0 with UF+NX.
- Undefined:
  - Every half-exponent ≤ 0 flushes to signed zero with UF=1, NX=1, regardless of exactness.
  - Saves the variable shifter.

## Test plan
- FP16 pair: 0x3F800000 then 0x40000000 (last) → one word 0x4000_3C00, out_last=1, out_flags=0, busy=0 the cycle after handshake.
- Odd tail: single 0xC0490FDB with last → 0x0000_C248, out_flags=NX (5'b00001), state IDLE.
- Specials pair: 0x47800000 then 0x7FC00000 (last) → 0x7E00_7C00, out_flags=NV|OF|NX (5'b10101); flags_sticky matches; pulse flags_clr → 0.
- Subnormal: 0x33800000 then 0x00000000 (last) → with macro 0x0000_0001, flags 0; without macro 0x0000_0000, flags UF|NX.
- FP32 backpressure: 3 beats, out_ready low 3 cycles after first word → out_data/out_flags stable, in_ready=0 while stalled, all 3 words delivered in order with in_flags intact.
- Reset in RUN16_HI after first half accepted → all outputs 0. A following FP16 pair 0x3F800000/0x40000000 produces 0x4000_3C00 with no stale half.
